// File: rtl/bp_cache_assoc.sv
// Set-associative branch-prediction cache: two combinational lookup ports, one write/update port
// with saturating-counter mode, per-set round-robin victims, and a multi-cycle flush sweep.
// Optional lookup statistics are enabled by defining BP_CACHE_STATS_EN.
module bp_cache_assoc #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 2,
    parameter int LINES  = 16,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] ra0,
    output logic [DWIDTH-1:0] dout0,
    output logic              hit0,
    input  logic [AWIDTH-1:0] ra1,
    output logic [DWIDTH-1:0] dout1,
    output logic              hit1,
    input  logic [AWIDTH-1:0] wa,
    input  logic              we,
    input  logic              wmode,
    input  logic [DWIDTH-1:0] din,
    input  logic              taken,
    input  logic              flush,
`ifdef BP_CACHE_STATS_EN
    input  logic              lookup0,
    output logic [31:0]       nlook0,
    output logic [31:0]       nhit0,
`endif
    output logic              busy
);

    localparam int SETS = LINES / WAYS;
    localparam int IW   = $clog2(SETS);
    localparam int TW   = AWIDTH - IW;
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    localparam logic [IW-1:0]     LAST_SET = IW'(SETS - 1);
    localparam logic [DWIDTH-1:0] CNT_MAX  = '1;
    localparam logic [DWIDTH-1:0] WEAK_T   = DWIDTH'(1) << (DWIDTH - 1);
    localparam logic [DWIDTH-1:0] WEAK_NT  = WEAK_T - DWIDTH'(1);

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [WW-1:0]     rr_q    [SETS];
    logic [WW-1:0]     rr_d    [SETS];
    logic [TW-1:0]     tag_q   [SETS][WAYS];
    logic [DWIDTH-1:0] data_q  [SETS][WAYS];
    logic [0:0]        state_q, state_d;
    logic [IW-1:0]     sweep_q, sweep_d;

    // ---------------- lookup ports ----------------
    logic [AWIDTH-1:0] rd_addr [2];
    logic [1:0]        rd_hit;
    logic [DWIDTH-1:0] rd_data [2];

    assign rd_addr[0] = ra0;
    assign rd_addr[1] = ra1;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_hit[p]  = 1'b0;
            rd_data[p] = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (state_q == ST_IDLE && valid_q[rd_addr[p][IW-1:0]][w] &&
                    tag_q[rd_addr[p][IW-1:0]][w] == rd_addr[p][AWIDTH-1:IW]) begin
                    rd_hit[p]  = 1'b1;
                    rd_data[p] = data_q[rd_addr[p][IW-1:0]][w];
                end
            end
        end
    end

    assign hit0  = rd_hit[0];
    assign dout0 = rd_data[0];
    assign hit1  = rd_hit[1];
    assign dout1 = rd_data[1];
    assign busy  = (state_q == ST_SWEEP);

    // ---------------- write / update path ----------------
    logic [IW-1:0]     wr_set;
    logic [TW-1:0]     wr_tag;
    logic              wr_en;
    logic              wr_hit, free_found;
    logic [WW-1:0]     hit_way, free_way, wr_way;
    logic [DWIDTH-1:0] cur_data, wr_data;

    assign wr_set = wa[IW-1:0];
    assign wr_tag = wa[AWIDTH-1:IW];
    assign wr_en  = reset && we && !flush && (state_q == ST_IDLE);

    always_comb begin
        wr_hit     = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        // Descending scan leaves the lowest-index invalid way selected.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[wr_set][w]) begin
                free_found = 1'b1;
                free_way   = WW'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[wr_set][w] && tag_q[wr_set][w] == wr_tag) begin
                wr_hit  = 1'b1;
                hit_way = WW'(w);
            end
        end
        wr_way   = wr_hit ? hit_way : (free_found ? free_way : rr_q[wr_set]);
        cur_data = data_q[wr_set][wr_way];
        if (!wmode) begin
            wr_data = din;
        end else if (!wr_hit) begin
            wr_data = taken ? WEAK_T : WEAK_NT;
        end else if (taken) begin
            wr_data = (cur_data == CNT_MAX) ? CNT_MAX : cur_data + DWIDTH'(1);
        end else begin
            wr_data = (cur_data == '0) ? '0 : cur_data - DWIDTH'(1);
        end
    end

    // ---------------- control next state ----------------
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_SWEEP;
                    sweep_d = '0;
                end else if (we) begin
                    valid_d[wr_set][wr_way] = 1'b1;
                    if (!wr_hit && !free_found) begin
                        rr_d[wr_set] = (WAYS == 1) ? '0 : rr_q[wr_set] + WW'(1);
                    end
                end
            end
            ST_SWEEP: begin
                valid_d[sweep_q] = '0;
                sweep_d          = sweep_q + IW'(1);
                if (sweep_q == LAST_SET) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sweep_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
        end
    end

    // NOTE: tag/data arrays are not reset; valid bits alone gate their visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_set][wr_way]  <= wr_tag;
            data_q[wr_set][wr_way] <= wr_data;
        end
    end

`ifdef BP_CACHE_STATS_EN
    logic [31:0] nlook_q, nhit_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            nlook_q <= '0;
            nhit_q  <= '0;
        end else if (state_q == ST_IDLE && flush) begin
            nlook_q <= '0;
            nhit_q  <= '0;
        end else begin
            if (lookup0)         nlook_q <= nlook_q + 32'd1;
            if (lookup0 && hit0) nhit_q  <= nhit_q + 32'd1;
        end
    end

    assign nlook0 = nlook_q;
    assign nhit0  = nhit_q;
`endif

endmodule

// File: tb/tb_bp_cache_assoc.sv
// Self-checking bench for bp_cache_assoc (LINES=8, WAYS=2): directed scenarios then random traffic,
// every cycle compared against a behavioural model of the cache rules.
module tb_bp_cache_assoc;

    localparam int AW   = 32;
    localparam int DW   = 2;
    localparam int NL   = 8;
    localparam int NW   = 2;
    localparam int SETS = NL / NW;
    localparam int MAXV = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] ra0 = '0, ra1 = '0, wa = '0;
    logic [DW-1:0] dout0, dout1, din = '0;
    logic          hit0, hit1, busy;
    logic          we = 1'b0, wmode = 1'b0, taken = 1'b0, flush = 1'b0;
    logic          lookup0 = 1'b1;
`ifdef BP_CACHE_STATS_EN
    logic [31:0]   nlook0, nhit0;
`endif

    bp_cache_assoc #(.AWIDTH(AW), .DWIDTH(DW), .LINES(NL), .WAYS(NW)) dut (
        .clk(clk), .reset(reset),
        .ra0(ra0), .dout0(dout0), .hit0(hit0),
        .ra1(ra1), .dout1(dout1), .hit1(hit1),
        .wa(wa), .we(we), .wmode(wmode), .din(din), .taken(taken), .flush(flush),
`ifdef BP_CACHE_STATS_EN
        .lookup0(lookup0), .nlook0(nlook0), .nhit0(nhit0),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each set is a small table of (valid, tag, value) plus a victim pointer.
    bit      m_known = 0;
    bit      mv  [SETS][NW];
    longint  mt  [SETS][NW];
    int      md  [SETS][NW];
    int      mrr [SETS];
    bit      m_busy = 0;
    int      m_sk = 0;
    longint  m_nlook = 0, m_nhit = 0;

    function automatic void m_lookup(input logic [AW-1:0] a, output bit h, output int d);
        int s = int'(a % SETS);
        longint t = longint'(a / SETS);
        h = 0;
        d = 0;
        if (m_busy) return;
        for (int w = 0; w < NW; w++)
            if (mv[s][w] && mt[s][w] == t) begin
                h = 1;
                d = md[s][w];
            end
    endfunction

    task automatic m_write();
        int s = int'(wa % SETS);
        longint t = longint'(wa / SETS);
        int way = -1;
        for (int w = 0; w < NW; w++)
            if (mv[s][w] && mt[s][w] == t) way = w;
        if (way >= 0) begin
            if (!wmode) md[s][way] = int'(din);
            else if (taken) md[s][way] = (md[s][way] + 1 > MAXV) ? MAXV : md[s][way] + 1;
            else md[s][way] = (md[s][way] - 1 < 0) ? 0 : md[s][way] - 1;
        end else begin
            for (int w = NW - 1; w >= 0; w--)
                if (!mv[s][w]) way = w;
            if (way < 0) begin
                way = mrr[s];
                mrr[s] = (mrr[s] + 1) % NW;
            end
            mv[s][way] = 1;
            mt[s][way] = t;
            if (!wmode) md[s][way] = int'(din);
            else md[s][way] = taken ? (1 << (DW - 1)) : (1 << (DW - 1)) - 1;
        end
    endtask

    task automatic model_step();
        bit h;
        int d;
        m_lookup(ra0, h, d);
        if (!reset) begin
            m_known = 1;
            m_busy  = 0;
            m_sk    = 0;
            m_nlook = 0;
            m_nhit  = 0;
            for (int s = 0; s < SETS; s++) begin
                mrr[s] = 0;
                for (int w = 0; w < NW; w++) mv[s][w] = 0;
            end
            return;
        end
        if (!m_busy && flush) begin
            m_nlook = 0;
            m_nhit  = 0;
        end else begin
            if (lookup0) m_nlook = (m_nlook + 1) % 64'h1_0000_0000;
            if (lookup0 && h) m_nhit = (m_nhit + 1) % 64'h1_0000_0000;
        end
        if (m_busy) begin
            for (int w = 0; w < NW; w++) mv[m_sk][w] = 0;
            m_sk++;
            if (m_sk == SETS) m_busy = 0;
        end else if (flush) begin
            m_busy = 1;
            m_sk   = 0;
        end else if (we) begin
            m_write();
        end
    endtask

    task automatic check_outputs();
        bit h;
        int d;
        if (!m_known) return;
        m_lookup(ra0, h, d);
        check("hit0", 32'(hit0), 32'(h));
        check("dout0", 32'(dout0), 32'(d));
        m_lookup(ra1, h, d);
        check("hit1", 32'(hit1), 32'(h));
        check("dout1", 32'(dout1), 32'(d));
        check("busy", 32'(busy), 32'(m_busy));
`ifdef BP_CACHE_STATS_EN
        check("nlook0", nlook0, 32'(m_nlook));
        check("nhit0", nhit0, 32'(m_nhit));
`endif
    endtask

    // One cycle: compare settled outputs before the edge, then advance the model at the edge.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic m, input logic [DW-1:0] d, input logic tk);
        we = 1'b1; wa = a; wmode = m; din = d; taken = tk;
        tick();
        we = 1'b0;
        tick();
    endtask

    initial begin
        // Reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        ra0 = 32'h7;
        tick();
        check("reset_hit0", 32'(hit0), 32'd0);

        // Basic store and overwrite
        wr(32'h7, 1'b0, 2'b11, 1'b0);
        wr(32'h7, 1'b0, 2'b01, 1'b0);

        // Fill set 3, then round-robin evictions
        ra1 = 32'h13;
        wr(32'h13, 1'b0, 2'b10, 1'b0);
        wr(32'h23, 1'b0, 2'b11, 1'b0);
        ra1 = 32'h33;
        wr(32'h33, 1'b0, 2'b01, 1'b0);
        ra0 = 32'h13;
        wr(32'h43, 1'b0, 2'b00, 1'b0);
        ra0 = 32'h7;
        tick();

        // Saturating counter: allocate, climb to max, fall to zero
        ra0 = 32'h5;
        wr(32'h5, 1'b1, 2'b00, 1'b1);
        repeat (2) wr(32'h5, 1'b1, 2'b00, 1'b1);
        repeat (4) wr(32'h5, 1'b1, 2'b00, 1'b0);

        // Dual-port read, then write visibility only after the edge
        ra0 = 32'h5; ra1 = 32'h33;
        tick();
        wr(32'h5, 1'b0, 2'b10, 1'b0);

        // Flush with a same-cycle write, writes during sweep, then everything misses
        we = 1'b1; wa = 32'h6; din = 2'b11; wmode = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (5) tick();
        we = 1'b0;
        foreach (ra0[i]) if (i < 1) begin end
        ra0 = 32'h6; ra1 = 32'h43; tick();
        ra0 = 32'h33; ra1 = 32'h5; tick();
        ra0 = 32'h7; ra1 = 32'h13; tick();

        // Reset in the second sweep cycle
        wr(32'h9, 1'b0, 2'b10, 1'b0);
        ra0 = 32'h9;
        flush = 1'b1; tick();
        flush = 1'b0; tick();
        reset = 1'b0; tick();
        reset = 1'b1; tick();
        check("abort_busy", 32'(busy), 32'd0);
        wr(32'h9, 1'b0, 2'b11, 1'b0);
        tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            ra0     = 32'($urandom_range(0, 31));
            ra1     = 32'($urandom_range(0, 31));
            wa      = 32'($urandom_range(0, 31));
            we      = ($urandom_range(0, 9) < 7);
            wmode   = 1'($urandom);
            taken   = 1'($urandom);
            din     = DW'($urandom);
            lookup0 = 1'($urandom);
            flush   = ($urandom_range(0, 39) == 0);
            reset   = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
